// File: rtl/av2_coeff_pkg.sv
// Shared types and constants for the coefficient token decoder.
// The 6-bit tx_size port cannot hold 64, so the value 64 truncated to 6 bits (0) selects W=64.
package av2_coeff_pkg;

  localparam int MAX_TX       = 64;
  localparam int AW           = 12;   // log2(MAX_TX*MAX_TX)
  localparam int IW           = AW + 1;
  localparam int QSTEP_OFFSET = 4;
  localparam int COEFF_MAX    = 32767;

  typedef enum logic [2:0] {
    ST_IDLE, ST_GET_EOB, ST_GET_LVL, ST_EMIT, ST_SUMMARY, ST_DONE
  } state_e;

  typedef struct packed {
    logic        sign;
    logic [14:0] mag;
  } level_t;

  localparam logic [5:0] TX_4  = 6'd4;
  localparam logic [5:0] TX_8  = 6'd8;
  localparam logic [5:0] TX_16 = 6'd16;
  localparam logic [5:0] TX_32 = 6'd32;
  localparam logic [5:0] TX_64 = 6'd0;

  function automatic logic [2:0] tx_log2(input logic [5:0] tx_size);
    case (tx_size)
      TX_4:    tx_log2 = 3'd2;
      TX_8:    tx_log2 = 3'd3;
      TX_16:   tx_log2 = 3'd4;
      TX_32:   tx_log2 = 3'd5;
      TX_64:   tx_log2 = 3'd6;
      default: tx_log2 = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/av2_coeff_dequant.sv
// Sign/magnitude level to saturated signed coefficient: level * q, clamped to +-COEFF_MAX.
module av2_coeff_dequant
  import av2_coeff_pkg::*;
(
  input  logic [15:0] symbol_i,
  input  logic [8:0]  q_i,
  output logic [15:0] coeff_o
);

  level_t      lvl;
  logic [23:0] prod;
  logic [14:0] sat;

  assign lvl  = level_t'(symbol_i);
  assign prod = {9'd0, lvl.mag} * {15'd0, q_i};
  assign sat  = (prod > 24'(COEFF_MAX)) ? 15'(COEFF_MAX) : prod[14:0];
  // Negating a zero magnitude yields 0, so a signed zero never escapes.
  assign coeff_o = lvl.sign ? (-{1'b0, sat}) : {1'b0, sat};

endmodule

// File: rtl/av2_coeff_token_decoder.sv
// Turns an EOB symbol plus level symbols into a full block of scan-ordered,
// dequantised coefficients, zero-filling positions at or beyond EOB.
module av2_coeff_token_decoder
  import av2_coeff_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [5:0]  tx_size_i,
  input  logic [3:0]  tx_type_i,
  input  logic [7:0]  qindex_i,
  input  logic [15:0] context_idx_i,
  input  logic [15:0] context_prob_i,
  input  logic [15:0] decoded_symbol_i,
  input  logic        symbol_valid_i,
  output logic        symbol_ready_o,
  output logic [15:0] coeff_out_o,
  output logic [11:0] coeff_addr_o,
  output logic        coeff_valid_o,
  input  logic        coeff_ready_i,
  output logic [15:0] num_coeffs_o,
  output logic        coeffs_valid_o,
  input  logic        coeffs_ready_i,
  output logic        done_o
);

  state_e        state_q, state_d;
  logic [2:0]    lg_q, lg_d;
  logic [8:0]    q_q, q_d;
  logic          col_q, col_d;
  logic [IW-1:0] idx_q, idx_d, eob_q, eob_d;
  logic [15:0]   num_q, num_d, coeff_q, coeff_d;

  logic [IW-1:0] n_blk, mask, idx_nxt, eob_sym, addr;
  logic [15:0]   lvl_coeff;
  logic          unused_ctx;

  assign unused_ctx = ^{context_idx_i, context_prob_i};

  assign n_blk   = IW'(1) << {lg_q, 1'b0};
  assign mask    = (IW'(1) << lg_q) - IW'(1);
  assign idx_nxt = idx_q + IW'(1);
  assign eob_sym = (decoded_symbol_i > 16'(n_blk)) ? n_blk : decoded_symbol_i[IW-1:0];

  // Column-major transposes (row, col) of the scan index; W is a power of two.
  assign addr = col_q ? (((idx_q & mask) << lg_q) | (idx_q >> lg_q)) : idx_q;

  av2_coeff_dequant u_dequant (
    .symbol_i (decoded_symbol_i),
    .q_i      (q_q),
    .coeff_o  (lvl_coeff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lg_q    <= '0;
      q_q     <= '0;
      col_q   <= 1'b0;
      idx_q   <= '0;
      eob_q   <= '0;
      num_q   <= '0;
      coeff_q <= '0;
    end else begin
      state_q <= state_d;
      lg_q    <= lg_d;
      q_q     <= q_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      eob_q   <= eob_d;
      num_q   <= num_d;
      coeff_q <= coeff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    q_d     = q_q;
    col_d   = col_q;
    idx_d   = idx_q;
    eob_d   = eob_q;
    num_d   = num_q;
    coeff_d = coeff_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        lg_d    = tx_log2(tx_size_i);
        q_d     = {1'b0, qindex_i} + 9'(QSTEP_OFFSET);
        col_d   = |tx_type_i;
        idx_d   = '0;
        state_d = ST_GET_EOB;
      end
      ST_GET_EOB: if (symbol_valid_i) begin
        eob_d = eob_sym;
        num_d = 16'(eob_sym);
        if (eob_sym == '0) begin
          coeff_d = '0;
          state_d = ST_EMIT;
        end else begin
          state_d = ST_GET_LVL;
        end
      end
      ST_GET_LVL: if (symbol_valid_i) begin
        coeff_d = lvl_coeff;
        state_d = ST_EMIT;
      end
      ST_EMIT: if (coeff_ready_i) begin
        idx_d = idx_nxt;
        if (idx_q == n_blk - IW'(1))  state_d = ST_SUMMARY;
        else if (idx_nxt < eob_q)     state_d = ST_GET_LVL;
        else                          coeff_d = '0;
      end
      ST_SUMMARY: if (coeffs_ready_i) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign symbol_ready_o = (state_q == ST_GET_EOB) || (state_q == ST_GET_LVL);
  assign coeff_valid_o  = (state_q == ST_EMIT);
  assign coeff_out_o    = coeff_q;
  assign coeff_addr_o   = addr[AW-1:0];
  assign num_coeffs_o   = num_q;
  assign coeffs_valid_o = (state_q == ST_SUMMARY);
  assign done_o         = (state_q == ST_DONE);

endmodule

// File: tb/tb_av2_coeff_token_decoder.sv
// Directed plus randomized blocks checked against a list-based reference of the whole block.
module tb_av2_coeff_token_decoder;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [5:0]  tx_size = '0;
  logic [3:0]  tx_type = '0;
  logic [7:0]  qindex = '0;
  logic [15:0] context_idx = '0, context_prob = '0, decoded_symbol = '0;
  logic        symbol_valid = 1'b0, coeff_ready = 1'b0, coeffs_ready = 1'b0;
  logic        symbol_ready, coeff_valid, coeffs_valid, done;
  logic [15:0] coeff_out, num_coeffs;
  logic [11:0] coeff_addr;

  int n_pass = 0, n_tot = 0;
  int unsigned q[$];

  always #5 clk = ~clk;

  av2_coeff_token_decoder dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .tx_size_i(tx_size), .tx_type_i(tx_type),
    .qindex_i(qindex), .context_idx_i(context_idx), .context_prob_i(context_prob),
    .decoded_symbol_i(decoded_symbol), .symbol_valid_i(symbol_valid), .symbol_ready_o(symbol_ready),
    .coeff_out_o(coeff_out), .coeff_addr_o(coeff_addr), .coeff_valid_o(coeff_valid),
    .coeff_ready_i(coeff_ready), .num_coeffs_o(num_coeffs), .coeffs_valid_o(coeffs_valid),
    .coeffs_ready_i(coeffs_ready), .done_o(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int deq(input int unsigned s, input int qi);
    int p;
    p = int'(s & 32'h7fff) * (qi + 4);
    if (p > 32767) p = 32767;
    return ((s & 32'h8000) != 0) ? -p : p;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_sr"}, {31'd0, symbol_ready}, 0);
    chk({tag, "_cout"}, {16'd0, coeff_out}, 0);
    chk({tag, "_caddr"}, {20'd0, coeff_addr}, 0);
    chk({tag, "_cv"}, {31'd0, coeff_valid}, 0);
    chk({tag, "_num"}, {16'd0, num_coeffs}, 0);
    chk({tag, "_csv"}, {31'd0, coeffs_valid}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
  endtask

  // Runs one block from IDLE to IDLE. tsz is the raw tx_size encoding.
  task automatic run_block(input logic [5:0] tsz, input int tt, input int qi,
                           input int unsigned syms[$], input int rdy_pct, input int gap_pct);
    int w, n, eob, ncons, nemit, cyc;
    int unsigned exp_a[$];
    logic [15:0] exp_c[$];
    logic stalled;
    logic [15:0] hold_c;
    logic [11:0] hold_a;
    w = (tsz == 6'd4) ? 4 : (tsz == 6'd8) ? 8 : (tsz == 6'd32) ? 32 : (tsz == 6'd0) ? 64 : 16;
    n = w * w;
    eob = (syms[0] > n) ? n : int'(syms[0]);
    for (int i = 0; i < n; i++) begin
      exp_a.push_back((tt != 0) ? (i % w) * w + i / w : i);
      exp_c.push_back((i < eob) ? 16'(deq(syms[i+1], qi)) : 16'd0);
    end
    @(negedge clk);
    tx_size = tsz; tx_type = tt[3:0]; qindex = qi[7:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ncons = 0; nemit = 0; cyc = 0; stalled = 1'b0; hold_c = '0; hold_a = '0;
    while (nemit < n && cyc < 20 * n + 200) begin
      symbol_valid   = ($urandom_range(99) >= gap_pct) && (ncons < syms.size());
      decoded_symbol = symbol_valid ? 16'(syms[ncons]) : 16'($urandom);
      coeff_ready    = ($urandom_range(99) < rdy_pct);
      if (stalled) begin
        chk("stall_valid", {31'd0, coeff_valid}, 1);
        chk("stall_addr", {20'd0, coeff_addr}, {20'd0, hold_a});
        chk("stall_coeff", {16'd0, coeff_out}, {16'd0, hold_c});
      end
      if (symbol_valid && symbol_ready) ncons++;
      stalled = 1'b0;
      if (coeff_valid) begin
        if (coeff_ready) begin
          chk("addr", {20'd0, coeff_addr}, exp_a[nemit]);
          chk("coeff", {16'd0, coeff_out}, {16'd0, exp_c[nemit]});
          nemit++;
        end else begin
          stalled = 1'b1; hold_a = coeff_addr; hold_c = coeff_out;
        end
      end
      @(negedge clk);
      cyc++;
    end
    symbol_valid = 1'b0; coeff_ready = 1'b0;
    chk("block_timeout", nemit, n);
    chk("num_coeffs", {16'd0, num_coeffs}, eob);
    chk("symbols_used", ncons, eob + 1);
    repeat ($urandom_range(3)) begin
      chk("summary_hold", {31'd0, coeffs_valid}, 1);
      chk("done_early", {31'd0, done}, 0);
      @(negedge clk);
    end
    chk("summary", {31'd0, coeffs_valid}, 1);
    coeffs_ready = 1'b1;
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 1);
    chk("summary_clr", {31'd0, coeffs_valid}, 0);
    coeffs_ready = 1'b0;
    @(negedge clk);
    chk("done_once", {31'd0, done}, 0);
    chk("idle_cv", {31'd0, coeff_valid}, 0);
  endtask

  initial begin
    logic [5:0] tsz_tab[5];
    int w, e, t;
    tsz_tab[0] = 6'd4; tsz_tab[1] = 6'd8; tsz_tab[2] = 6'd16; tsz_tab[3] = 6'd32; tsz_tab[4] = 6'd5;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    q = '{3, 5, 32'h8002, 1};
    run_block(6'd4, 0, 0, q, 100, 0);
    q = '{2, 1, 1};
    run_block(6'd4, 1, 0, q, 100, 0);
    q = '{2, 32'h7fff, 32'hffff};
    run_block(6'd8, 0, 255, q, 100, 0);
    q.delete();
    q.push_back(100);
    for (int i = 0; i < 100; i++) q.push_back($urandom_range(300));
    run_block(6'd4, 0, 3, q, 100, 0);
    q.delete();
    q.push_back(40);
    for (int i = 0; i < 40; i++) q.push_back($urandom & 32'hffff);
    run_block(6'd8, 1, 10, q, 50, 40);
    q = '{0};
    run_block(6'd0, 0, 7, q, 100, 0);

    for (int b = 0; b < 6; b++) begin
      t = $urandom_range(4);
      w = (t == 4) ? 16 : (4 << t);
      e = $urandom_range(w * w + 3);
      q.delete();
      q.push_back(e);
      for (int i = 0; i < w * w; i++)
        q.push_back(($urandom_range(3) == 0) ? ($urandom & 32'hffff)
                                             : ($urandom_range(40) | ($urandom_range(1) << 15)));
      run_block(tsz_tab[t], ($urandom_range(1) == 1) ? int'($urandom_range(15, 1)) : 0,
                $urandom_range(255), q, $urandom_range(100, 50), $urandom_range(50));
    end

    // Abort mid-block: W=64, every symbol 7, so EOB=7 and zero fill is underway by now.
    @(negedge clk);
    tx_size = 6'd0; tx_type = 4'd1; qindex = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; symbol_valid = 1'b1; decoded_symbol = 16'd7; coeff_ready = 1'b1;
    repeat (50) @(negedge clk);
    chk("mid_active", {31'd0, coeff_valid}, 1);
    chk("mid_num", {16'd0, num_coeffs}, 7);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    check_zero("rst_hold");
    symbol_valid = 1'b0; coeff_ready = 1'b0;
    rst_n = 1'b1;
    q = '{1, 32'h8001};
    run_block(6'd4, 0, 0, q, 100, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/av2_coeff_token_decoder.md
Name: av2_coeff_token_decoder

Overview:
Converts a stream of entropy-decoded symbols for one transform block into dequantised, scan-ordered residual coefficients. The first symbol is the end-of-block count; each following symbol is one sign/magnitude level. Sits between the arithmetic symbol decoder and the coefficient buffer that feeds the inverse transform.

Parameters:
MAX_TX, 64, largest transform edge in samples; addresses span 0..MAX_TX*MAX_TX-1 (4096).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; begins a block when sampled high in IDLE
tx_size  in  6  transform edge W: 4/8/16/32/64; any other value is treated as 16
tx_type  in  4  0 = row-major scan; any non-zero value = column-major scan
qindex  in  8  quantiser index
context_idx  in  16  reserved, ignored
context_prob  in  16  reserved, ignored
decoded_symbol  in  16  symbol payload
symbol_valid  in  1  symbol present
symbol_ready  out  1  symbol accepted when valid&ready
coeff_out  out  16  signed dequantised coefficient
coeff_addr  out  12  buffer address of coeff_out
coeff_valid  out  1  coefficient present
coeff_ready  in  1  coefficient consumed when valid&ready
num_coeffs  out  16  clamped EOB of the last block
coeffs_valid  out  1  block summary available
coeffs_ready  in  1  summary consumed
done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM enters IDLE.
- FSM states: IDLE, GET_EOB, GET_LVL, EMIT, SUMMARY, DONE.
- IDLE:
  - When start=1: latch W, N=W*W, q=qindex+4 (9 bits) and scan mode.
  - Clear idx, then go to GET_EOB.
  - start is ignored in every other state.
- GET_EOB:
  - symbol_ready=1.
  - On handshake: eob=min(decoded_symbol, N), register num_coeffs=eob.
  - If eob=0, go to EMIT with a zero coefficient; otherwise go to GET_LVL.
- GET_LVL:
  - symbol_ready=1.
  - On handshake: sign=decoded_symbol[15], mag=decoded_symbol[14:0].
  - prod=mag*q (24 bits unsigned), then apply sign.
  - Saturate to +32767 / -32767; -0 becomes 0.
  - Go to EMIT.
- Positions idx >= eob:
  - Consume no symbol; emit coefficient 0.
  - Path is GET_LVL/EOB decision → EMIT directly.
- EMIT:
  - coeff_valid=1; coeff_out and coeff_addr stay stable until coeff_ready=1.
  - On handshake: idx++.
  - If idx was N-1, go to SUMMARY.
  - Else if the new idx < eob, go to GET_LVL; else stay in EMIT with 0.
  - coeff_valid drops the cycle after the final handshake unless the next coefficient is ready.
- Address:
  - Row-major: addr = idx.
  - Column-major: addr = (idx mod W)*W + idx/W.
  - W is a power of two, so use shifts and masks; addr is always < N <= 4096.
- SUMMARY:
  - coeffs_valid=1 until coeffs_ready=1.
  - Then go to DONE.
- DONE:
  - done=1 for exactly one cycle; coeffs_valid=0.
  - Next state is IDLE; start still high in that IDLE cycle launches a new block.
- Latency:
  - Symbol handshake at cycle k gives coeff_valid=1 at k+1.
  - Zero fill runs at 1 coefficient/cycle while coeff_ready=1.
- symbol_ready is 0 outside GET_EOB/GET_LVL; symbols offered then are not consumed.
- symbol_valid with symbol_ready=0 has no effect.
- num_coeffs holds its value until the next GET_EOB handshake.
- Async reset mid-block aborts immediately to the reset state; partial outputs are discarded.

Decomposition:
- Shared package av2_coeff_pkg holds:
  - the FSM state enum;
  - QSTEP_OFFSET=4;
  - COEFF_MAX=32767;
  - the legal tx_size encodings and log2 lookup function.
- One natural sub-module: av2_coeff_dequant, a combinational block computing sign, magnitude, q multiply and saturation.

Test Plan:
- W=4, tx_type=0, qindex=0, symbols {3, 5, 0x8002, 1}, ready always 1:
  - (addr,coeff) = (0,20),(1,-8),(2,4),(3..15,0);
  - num_coeffs=3, done pulses once.
- W=4, tx_type=1, eob=2, levels {1,1}, qindex=0:
  - addresses are 0 then 4, and then 8,12,1,5,… for the zeros.
- qindex=255, level 0x7FFF:
  - coeff_out=32767; sign bit set gives -32767.
- eob symbol 100 with W=4:
  - num_coeffs=16; exactly 17 symbols consumed in total.
- coeff_ready toggles 1-0-1 and symbol_valid has gaps:
  - coeff_out/coeff_addr stay stable while stalled;
  - no coefficient is lost or duplicated.
- eob=0 with W=64:
  - 4096 zeros at addresses 0..4095;
  - coeffs_valid holds until coeffs_ready; assert reset mid-stream → all outputs 0 the next cycle.
